// File: rtl/multizone_timekeeper_pkg.sv
// Shared types, constants and helpers for the multi-zone timekeeper.
package multizone_timekeeper_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SET_HOUR   = 2'd1,
    SET_MIN    = 2'd2,
    SET_OFFSET = 2'd3
  } state_t;

  localparam int MIN_PER_DAY  = 1440;
  localparam int SEC_PER_MIN  = 60;
  localparam int MIN_PER_HOUR = 60;
  localparam int HOUR_PER_DAY = 24;

  // Signed zone offset, counted in OFFSET_STEP_MIN steps.
  typedef logic signed [6:0] offset_t;

  // Modular +/-1 on a 0..top field; simultaneous inc and dec cancel.
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] top,
                                          input logic inc, input logic dec);
    logic [5:0] r;
    r = v;
    if (inc && !dec)      r = (v == top) ? 6'd0 : v + 6'd1;
    else if (dec && !inc) r = (v == 6'd0) ? top : v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/multizone_timekeeper_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect: one event per button press.
module btn_edge_sync (
  input  logic clk100hz,
  input  logic reset,
  input  logic btn_i,
  output logic event_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign event_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/multizone_timekeeper.sv
// UTC base clock with NUM_ZONES offset local views, button-driven set mode and day-carry strobes.
// Optional blinking of edited digits is enabled with `define MULTIZONE_TIMEKEEPER_BLINK_EN.
module multizone_timekeeper
  import multizone_timekeeper_pkg::*;
#(
  parameter  int NUM_ZONES        = 2,
  parameter  int TICKS_PER_SEC    = 100,
  parameter  int OFFSET_STEP_MIN  = 15,
  parameter  int MAX_OFFSET_STEPS = 56,
  localparam int ZS_W             = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                   clk100hz,
  input  logic                   reset,
  input  logic                   btn_mode,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic [ZS_W-1:0]        zone_sel,
  output logic                   tick_1hz,
  output logic [5:0]             seconds,
  output logic [NUM_ZONES*5-1:0] zone_hours,
  output logic [NUM_ZONES*6-1:0] zone_mins,
  output logic [NUM_ZONES-1:0]   day_carry,
  output logic [1:0]             edit_field,
  output logic [1:0]             blink_mask
);

  localparam int              PS_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam offset_t         OFF_MAX = offset_t'(MAX_OFFSET_STEPS);
  localparam offset_t         OFF_MIN = offset_t'(-MAX_OFFSET_STEPS);

  state_t          state_q;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hour_q, hour_d;
  offset_t         offset_q [NUM_ZONES];
  offset_t         offset_d [NUM_ZONES];
  logic            mode_ev, up_ev, down_ev;
  logic            tick;
  logic [11:0]     base_mod;

  btn_edge_sync u_sync_mode (.clk100hz(clk100hz), .reset(reset), .btn_i(btn_mode), .event_o(mode_ev));
  btn_edge_sync u_sync_up   (.clk100hz(clk100hz), .reset(reset), .btn_i(btn_up),   .event_o(up_ev));
  btn_edge_sync u_sync_down (.clk100hz(clk100hz), .reset(reset), .btn_i(btn_down), .event_o(down_ev));

  assign tick       = (state_q == RUN) && (presc_q == PS_LAST);
  assign tick_1hz   = tick;
  assign seconds    = sec_q;
  assign edit_field = state_q;

  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else if (mode_ev) begin
      unique case (state_q)
        RUN:        state_q <= SET_HOUR;
        SET_HOUR:   state_q <= SET_MIN;
        SET_MIN:    state_q <= SET_OFFSET;
        SET_OFFSET: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    presc_d  = presc_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    offset_d = offset_q;
    unique case (state_q)
      RUN: begin
        if (tick) begin
          presc_d = '0;
          if (sec_q == 6'(SEC_PER_MIN - 1)) begin
            sec_d = '0;
            if (min_q == 6'(MIN_PER_HOUR - 1)) begin
              min_d  = '0;
              hour_d = (hour_q == 5'(HOUR_PER_DAY - 1)) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
        // A coincident tick keeps its minute carry (matching day_carry); only the sub-minute count restarts.
        if (mode_ev) begin
          presc_d = '0;
          sec_d   = '0;
        end
      end
      SET_HOUR: begin
        if (!mode_ev) hour_d = 5'(step_mod(6'(hour_q), 6'(HOUR_PER_DAY - 1), up_ev, down_ev));
      end
      SET_MIN: begin
        if (!mode_ev) min_d = step_mod(min_q, 6'(MIN_PER_HOUR - 1), up_ev, down_ev);
      end
      SET_OFFSET: begin
        for (int z = 0; z < NUM_ZONES; z++) begin
          if (!mode_ev && (32'(zone_sel) == z)) begin
            if (up_ev && !down_ev && (offset_q[z] < OFF_MAX))
              offset_d[z] = offset_q[z] + offset_t'(1);
            else if (down_ev && !up_ev && (offset_q[z] > OFF_MIN))
              offset_d[z] = offset_q[z] - offset_t'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      // NOTE: the offset array is tiny and must read 0 after reset, so it is reset like any flop rather than left as uninitialised storage.
      for (int z = 0; z < NUM_ZONES; z++) offset_q[z] <= '0;
    end else begin
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      offset_q <= offset_d;
    end
  end

  assign base_mod = 12'(hour_q) * 12'(MIN_PER_HOUR) + 12'(min_q);

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    logic [11:0] sum;
    logic [11:0] local_min;

    // The 12-bit sum is exact modulo 4096; the offset sign tells which side of the day it can spill.
    always_comb begin
      sum = base_mod + 12'(int'(offset_q[z]) * OFFSET_STEP_MIN);
      if (offset_q[z][6]) local_min = sum[11] ? sum + 12'(MIN_PER_DAY) : sum;
      else                local_min = (sum >= 12'(MIN_PER_DAY)) ? sum - 12'(MIN_PER_DAY) : sum;
    end

    assign zone_hours[5*z +: 5] = 5'(local_min / 12'(MIN_PER_HOUR));
    assign zone_mins[6*z +: 6]  = 6'(local_min % 12'(MIN_PER_HOUR));
    assign day_carry[z]         = tick && (sec_q == 6'(SEC_PER_MIN - 1)) &&
                                  (local_min == 12'(MIN_PER_DAY - 1));
  end

`ifdef MULTIZONE_TIMEKEEPER_BLINK_EN
  localparam int BLINK_HALF = (TICKS_PER_SEC / 4 > 0) ? TICKS_PER_SEC / 4 : 1;
  localparam int BL_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BL_W-1:0] blink_cnt_q;
  logic            blink_q;

  always_ff @(posedge clk100hz or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BL_W'(1);
    end
  end

  always_comb begin
    blink_mask = 2'b00;
    if (blink_q) begin
      unique case (state_q)
        RUN:        blink_mask = 2'b00;
        SET_HOUR:   blink_mask = 2'b01;
        SET_MIN:    blink_mask = 2'b10;
        SET_OFFSET: blink_mask = 2'b11;
      endcase
    end
  end
`else
  assign blink_mask = 2'b00;
`endif

endmodule

// File: tb/tb_multizone_timekeeper.sv
// Directed bench for multizone_timekeeper (2 zones, 4 ticks/s) with an expected-value scoreboard.
module tb_multizone_timekeeper;

  logic        clk100hz = 1'b0;
  logic        reset;
  logic        btn_mode, btn_up, btn_down;
  logic [0:0]  zone_sel;
  logic        tick_1hz;
  logic [5:0]  seconds;
  logic [9:0]  zone_hours;
  logic [11:0] zone_mins;
  logic [1:0]  day_carry;
  logic [1:0]  edit_field;
  logic [1:0]  blink_mask;

  multizone_timekeeper #(
    .NUM_ZONES(2), .TICKS_PER_SEC(4), .OFFSET_STEP_MIN(15), .MAX_OFFSET_STEPS(56)
  ) dut (
    .clk100hz(clk100hz), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .zone_sel(zone_sel), .tick_1hz(tick_1hz), .seconds(seconds),
    .zone_hours(zone_hours), .zone_mins(zone_mins), .day_carry(day_carry),
    .edit_field(edit_field), .blink_mask(blink_mask)
  );

  always #5 clk100hz = ~clk100hz;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model of the editable state.
  int mh, mm, mst;
  int moff [2];

  logic carry_watch = 1'b0;
  int   carry_hits  = 0;

  always @(negedge clk100hz) if (carry_watch && day_carry != 2'b00) carry_hits++;

  function automatic int local_min(input int h, input int m, input int off);
    int v;
    v = (h * 60 + m + off * 15) % 1440;
    if (v < 0) v += 1440;
    return v;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %0d with no expected value queued", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    check(obs);
  endtask

  task automatic check_zones(input string tag);
    int l;
    for (int z = 0; z < 2; z++) begin
      l = local_min(mh, mm, moff[z]);
      expect_val($sformatf("%s_h%0d", tag, z), 32'(l / 60));
      expect_val($sformatf("%s_m%0d", tag, z), 32'(l % 60));
    end
    for (int z = 0; z < 2; z++) begin
      check(32'(zone_hours[5*z +: 5]));
      check(32'(zone_mins[6*z +: 6]));
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_tick"},  32'(tick_1hz),   0);
    cmp({tag, "_sec"},   32'(seconds),    0);
    cmp({tag, "_zh"},    32'(zone_hours), 0);
    cmp({tag, "_zm"},    32'(zone_mins),  0);
    cmp({tag, "_dc"},    32'(day_carry),  0);
    cmp({tag, "_edit"},  32'(edit_field), 0);
    cmp({tag, "_blink"}, 32'(blink_mask), 0);
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; mst = 0; moff[0] = 0; moff[1] = 0;
  endtask

  task automatic model_apply(input logic m, input logic u, input logic d);
    if (m) begin
      mst = (mst + 1) % 4;
    end else if (u ^ d) begin
      case (mst)
        1: mh = (mh + (u ? 1 : 23)) % 24;
        2: mm = (mm + (u ? 1 : 59)) % 60;
        3: begin
          if (u && moff[zone_sel] < 56)  moff[zone_sel]++;
          if (d && moff[zone_sel] > -56) moff[zone_sel]--;
        end
        default: ;
      endcase
    end
  endtask

  // Event lands on the 3rd rising edge after the press starts; 4 idle cycles follow release.
  task automatic press(input logic m, input logic u, input logic d, input int hold);
    btn_mode = m; btn_up = u; btn_down = d;
    repeat (hold) @(negedge clk100hz);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (4) @(negedge clk100hz);
    model_apply(m, u, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk100hz);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_tick, n_bad, last_k, first_k, n_dc0, n_dc1, dc_z1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; zone_sel = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check_zero("rst_init");
    @(negedge clk100hz);
    reset = 1'b0;

    // One minute of free running from reset.
    n_tick = 0; n_bad = 0; last_k = -1; first_k = -1;
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk100hz);
      if (tick_1hz) begin
        if (last_k >= 0 && k - last_k != 4) n_bad++;
        if (first_k < 0) first_k = k;
        last_k = k;
        n_tick++;
      end
    end
    mm = 1;
    cmp("tick_count", 32'(n_tick), 60);
    cmp("tick_spacing_bad", 32'(n_bad), 0);
    cmp("tick_first", 32'(first_k), 3);
    cmp("sec_after_1min", 32'(seconds), 0);
    check_zones("run_1min");

    // Base 23:59, zone1 +1 h, then cross midnight.
    do_reset();
    press(1, 0, 0, 1);
    cmp("edit_sethour", 32'(edit_field), 1);
    repeat (23) press(0, 1, 0, 1);
    press(1, 0, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 1);
    zone_sel = 1'b1;
    repeat (4) press(0, 1, 0, 1);
    check_zones("set_2359");
    cmp("z1_hours_0059", 32'(zone_hours[9:5]), 0);
    cmp("z1_mins_0059", 32'(zone_mins[11:6]), 59);
    cmp("edit_setoffset", 32'(edit_field), 3);
    cmp("sec_held_set", 32'(seconds), 0);
    cmp("tick_in_set", 32'(tick_1hz), 0);
    press(1, 0, 0, 1);
    n_dc0 = 0; n_dc1 = 0; dc_z1 = -1;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk100hz);
      if (day_carry[0]) begin
        n_dc0++;
        dc_z1 = int'(zone_hours[9:5]) * 100 + int'(zone_mins[11:6]);
      end
      if (day_carry[1]) n_dc1++;
    end
    mh = 0; mm = 0;
    check_zones("after_midnight");
    cmp("dc0_pulses", 32'(n_dc0), 1);
    cmp("dc1_pulses", 32'(n_dc1), 0);
    cmp("z1_at_dc0", 32'(dc_z1), 59);
    cmp("sec_after_run", 32'(seconds), 3);

    // Offset saturation at -56 steps from base 05:00.
    do_reset();
    press(1, 0, 0, 1);
    repeat (5) press(0, 1, 0, 1);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    zone_sel = 1'b0;
    repeat (56) press(0, 0, 1, 1);
    check_zones("off_m56");
    cmp("z0_hours_m56", 32'(zone_hours[4:0]), 15);
    press(0, 0, 1, 1);
    check_zones("off_sat");
    press(0, 1, 0, 1);
    check_zones("off_m55");
    cmp("z0_mins_m55", 32'(zone_mins[5:0]), 15);

    // SET_MIN: simultaneous up/down cancels; a long hold counts once.
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    cmp("edit_setmin", 32'(edit_field), 2);
`ifndef MULTIZONE_TIMEKEEPER_BLINK_EN
    cmp("blink_off", 32'(blink_mask), 0);
`endif
    press(0, 1, 1, 2);
    check_zones("updown_cancel");
    cmp("z1_mins_cancel", 32'(zone_mins[11:6]), 0);
    press(0, 1, 0, 20);
    check_zones("held_up");
    cmp("z1_mins_held", 32'(zone_mins[11:6]), 1);

    // Offset edits across midnight never raise day_carry.
    do_reset();
    carry_watch = 1'b1;
    press(1, 0, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 1);
    repeat (30) press(0, 1, 0, 1);
    press(1, 0, 0, 1);
    zone_sel = 1'b0;
    repeat (4) press(0, 1, 0, 1);
    check_zones("z0_0030");
    cmp("z0_hours_0030", 32'(zone_hours[4:0]), 0);
    repeat (4) press(0, 0, 1, 1);
    check_zones("z0_2330");
    carry_watch = 1'b0;
    cmp("carry_on_edit", 32'(carry_hits), 0);

    // Asynchronous reset in the middle of an offset edit.
    press(1, 0, 0, 1);
    repeat (10) @(negedge clk100hz);
    cmp("sec_midcount", 32'(seconds), 3);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
    press(0, 1, 0, 1);
    check_zones("pre_reset");
    cmp("edit_pre_reset", 32'(edit_field), 3);
    #3 reset = 1'b1;
    #1 check_zero("rst_mid_edit");
    @(negedge clk100hz);
    reset = 1'b0;
    model_reset();
    @(negedge clk100hz);
    check_zones("post_reset");
    cmp("edit_post_reset", 32'(edit_field), 0);

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d queued expectations expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
